// File: rtl/io_ram_banked_if.sv
// Port bundle for io_ram_banked: two symmetric RAM ports plus collision status.
// The master drives requests; the slave (the RAM) returns read data and status.
interface io_ram_banked_if #(
    parameter int DW    = 8,
    parameter int AW    = 12,
    parameter int CNT_W = 8
);
    logic             en_porta;
    logic             wr_porta;
    logic [AW-1:0]    addra;
    logic [DW-1:0]    wr_dataa;
    logic [DW-1:0]    rd_dataa;
    logic             rd_valida;

    logic             en_portb;
    logic             wr_portb;
    logic [AW-1:0]    addrb;
    logic [DW-1:0]    wr_datab;
    logic [DW-1:0]    rd_datab;
    logic             rd_validb;

    logic             coll;
    logic [CNT_W-1:0] coll_cnt;
    logic             coll_clr;

    modport master (
        output en_porta, wr_porta, addra, wr_dataa,
        output en_portb, wr_portb, addrb, wr_datab,
        output coll_clr,
        input  rd_dataa, rd_valida, rd_datab, rd_validb,
        input  coll, coll_cnt
    );

    modport slave (
        input  en_porta, wr_porta, addra, wr_dataa,
        input  en_portb, wr_portb, addrb, wr_datab,
        input  coll_clr,
        output rd_dataa, rd_valida, rd_datab, rd_validb,
        output coll, coll_cnt
    );
endinterface

// File: rtl/io_ram_banked.sv
// Banked dual-port I/O RAM with same-address collision forwarding and counter.
// Define IO_RAM_OUT_REG_EN to add an output register stage (read latency 2).
module io_ram_banked #(
    parameter int DW     = 8,
    parameter int AW     = 12,
    parameter int BANK_W = 3,
    parameter int CNT_W  = 8
) (
    input logic            clk,
    input logic            rst_n,
    io_ram_banked_if.slave bus
);
    localparam int NB   = 1 << BANK_W;
    localparam int RW   = AW - BANK_W;
    localparam int ROWS = 1 << RW;

    logic [DW-1:0] mem [NB][ROWS];

    logic [BANK_W-1:0] bank_a, bank_b;
    logic [RW-1:0]     row_a, row_b;
    logic              wa, wb, ra, rb;
    logic              same, coll_now;
    logic              bk_rd_a, bk_rd_b;
    logic [DW-1:0]     fwd_a_d, fwd_b_d;

    assign bank_a = bus.addra[BANK_W-1:0];
    assign bank_b = bus.addrb[BANK_W-1:0];
    assign row_a  = bus.addra[AW-1:BANK_W];
    assign row_b  = bus.addrb[AW-1:BANK_W];

    assign wa = bus.en_porta & bus.wr_porta;
    assign ra = bus.en_porta & ~bus.wr_porta;
    assign wb = bus.en_portb & bus.wr_portb;
    assign rb = bus.en_portb & ~bus.wr_portb;

    assign same     = bus.en_porta & bus.en_portb & (bus.addra == bus.addrb);
    assign coll_now = same & (wa | wb);

    // A colliding read takes the other port's write data, so skip the bank.
    assign bk_rd_a = ra & ~coll_now;
    assign bk_rd_b = rb & ~coll_now;

    always_comb begin
        fwd_a_d = bus.wr_dataa;
        if (!wa) fwd_a_d = bus.wr_datab;
    end

    always_comb begin
        fwd_b_d = bus.wr_datab;
        if (coll_now && wa) fwd_b_d = bus.wr_dataa;
    end

    // Port A is written last so it wins a same-address write/write.
    always_ff @(posedge clk) begin
        if (wb) mem[bank_b][row_b] <= bus.wr_datab;
        if (wa) mem[bank_a][row_a] <= bus.wr_dataa;
    end

    logic [DW-1:0] q_a [NB];
    logic [DW-1:0] q_b [NB];

    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (bk_rd_a && bank_a == BANK_W'(b)) q_a[b] <= mem[b][row_a];
            if (bk_rd_b && bank_b == BANK_W'(b)) q_b[b] <= mem[b][row_b];
        end
    end

    logic              use_bank_a, use_bank_b;
    logic [BANK_W-1:0] sel_a, sel_b;
    logic [DW-1:0]     fwd_a, fwd_b;
    logic              valid_a, valid_b;
    logic              coll_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            use_bank_a <= 1'b0;
            sel_a      <= '0;
            fwd_a      <= '0;
            valid_a    <= 1'b0;
        end else begin
            valid_a <= ra;
            if (bk_rd_a) begin
                use_bank_a <= 1'b1;
                sel_a      <= bank_a;
            end else if (bus.en_porta) begin
                use_bank_a <= 1'b0;
                fwd_a      <= fwd_a_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            use_bank_b <= 1'b0;
            sel_b      <= '0;
            fwd_b      <= '0;
            valid_b    <= 1'b0;
        end else begin
            valid_b <= rb;
            if (bk_rd_b) begin
                use_bank_b <= 1'b1;
                sel_b      <= bank_b;
            end else if (bus.en_portb) begin
                use_bank_b <= 1'b0;
                fwd_b      <= fwd_b_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) coll_q <= 1'b0;
        else        coll_q <= coll_now;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.coll_cnt <= '0;
        end else if (bus.coll_clr) begin
            bus.coll_cnt <= '0;
        end else if (coll_now && bus.coll_cnt != {CNT_W{1'b1}}) begin
            bus.coll_cnt <= bus.coll_cnt + 1'b1;
        end
    end

    logic [DW-1:0] data1_a, data1_b;

    assign data1_a = use_bank_a ? q_a[sel_a] : fwd_a;
    assign data1_b = use_bank_b ? q_b[sel_b] : fwd_b;

`ifdef IO_RAM_OUT_REG_EN
    logic [DW-1:0] data2_a, data2_b;
    logic          valid2_a, valid2_b, coll2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data2_a  <= '0;
            data2_b  <= '0;
            valid2_a <= 1'b0;
            valid2_b <= 1'b0;
            coll2    <= 1'b0;
        end else begin
            data2_a  <= data1_a;
            data2_b  <= data1_b;
            valid2_a <= valid_a;
            valid2_b <= valid_b;
            coll2    <= coll_q;
        end
    end

    assign bus.rd_dataa  = data2_a;
    assign bus.rd_datab  = data2_b;
    assign bus.rd_valida = valid2_a;
    assign bus.rd_validb = valid2_b;
    assign bus.coll      = coll2;
`else
    assign bus.rd_dataa  = data1_a;
    assign bus.rd_datab  = data1_b;
    assign bus.rd_valida = valid_a;
    assign bus.rd_validb = valid_b;
    assign bus.coll      = coll_q;
`endif

endmodule

// File: tb/tb_io_ram_banked.sv
// Directed bench for io_ram_banked; a second instance with CNT_W=2 covers saturation.
module tb_io_ram_banked;
`ifdef IO_RAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    io_ram_banked_if #(.DW(8), .AW(12), .CNT_W(8)) bus ();
    io_ram_banked_if #(.DW(8), .AW(12), .CNT_W(2)) bus2 ();

    io_ram_banked #(.DW(8), .AW(12), .BANK_W(3), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    io_ram_banked #(.DW(8), .AW(12), .BANK_W(3), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.en_porta = 0; bus.wr_porta = 0; bus.addra = '0; bus.wr_dataa = '0;
        bus.en_portb = 0; bus.wr_portb = 0; bus.addrb = '0; bus.wr_datab = '0;
        bus.coll_clr = 0;
        bus2.en_porta = 0; bus2.wr_porta = 0; bus2.addra = '0; bus2.wr_dataa = '0;
        bus2.en_portb = 0; bus2.wr_portb = 0; bus2.addrb = '0; bus2.wr_datab = '0;
        bus2.coll_clr = 0;
    endtask

    task automatic opa(input logic en, input logic wr, input logic [11:0] a, input logic [7:0] d);
        bus.en_porta = en; bus.wr_porta = wr; bus.addra = a; bus.wr_dataa = d;
    endtask

    task automatic opb(input logic en, input logic wr, input logic [11:0] a, input logic [7:0] d);
        bus.en_portb = en; bus.wr_portb = wr; bus.addrb = a; bus.wr_datab = d;
    endtask

    task automatic settle();
        idle();
        repeat (LAT - 1) cyc();
    endtask

    task automatic ww2(input logic [7:0] d, input logic clr);
        bus2.en_porta = 1; bus2.wr_porta = 1; bus2.addra = 12'h010; bus2.wr_dataa = d;
        bus2.en_portb = 1; bus2.wr_portb = 1; bus2.addrb = 12'h010; bus2.wr_datab = ~d;
        bus2.coll_clr = clr;
    endtask

    initial begin
        idle();
        repeat (2) cyc();
        chk("rst rd_dataa", bus.rd_dataa, 8'h00);
        chk("rst rd_valida", bus.rd_valida, 1'b0);
        chk("rst rd_validb", bus.rd_validb, 1'b0);
        chk("rst coll", bus.coll, 1'b0);
        chk("rst coll_cnt", bus.coll_cnt, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        opa(1, 1, 12'h123, 8'h5A);
        cyc();
        opa(1, 0, 12'h123, 8'h00);
        cyc();
        settle();
        chk("t1 rd_dataa", bus.rd_dataa, 8'h5A);
        chk("t1 rd_valida", bus.rd_valida, 1'b1);
        cyc();
        chk("t1 valid drop", bus.rd_valida, 1'b0);
        chk("t1 hold", bus.rd_dataa, 8'h5A);

        opb(1, 1, 12'h300, 8'h3C);
        cyc();
        settle();
        chk("wfirst rd_datab", bus.rd_datab, 8'h3C);
        chk("wfirst rd_validb", bus.rd_validb, 1'b0);

        for (int i = 0; i < 16; i++) begin
            opa(1, 1, 12'(i), 8'(8'hA0 + i));
            cyc();
        end
        idle();
        for (int i = 0; i < 16; i++) begin
            opb(1, 0, 12'(i), 8'h00);
            cyc();
            settle();
            chk("t2 rd_datab", bus.rd_datab, 8'(8'hA0 + i));
            chk("t2 rd_validb", bus.rd_validb, 1'b1);
        end

        opb(1, 1, 12'h208, 8'h99);
        cyc();
        idle();

        opa(1, 1, 12'h040, 8'h11);
        opb(1, 1, 12'h040, 8'h22);
        cyc();
        idle();
        chk("t3 coll_cnt", bus.coll_cnt, 8'd1);
        settle();
        chk("t3 coll", bus.coll, 1'b1);
        chk("t3 rd_dataa", bus.rd_dataa, 8'h11);
        chk("t3 rd_datab", bus.rd_datab, 8'h11);
        cyc();
        chk("t3 coll drop", bus.coll, 1'b0);
        opb(1, 0, 12'h040, 8'h00);
        cyc();
        settle();
        chk("t3 readback", bus.rd_datab, 8'h11);

        opa(1, 1, 12'h200, 8'h77);
        opb(1, 0, 12'h200, 8'h00);
        cyc();
        idle();
        chk("t4 coll_cnt", bus.coll_cnt, 8'd2);
        settle();
        chk("t4 fwd rd_datab", bus.rd_datab, 8'h77);
        chk("t4 rd_validb", bus.rd_validb, 1'b1);
        chk("t4 coll", bus.coll, 1'b1);
        chk("t4 rd_valida", bus.rd_valida, 1'b0);

        opa(1, 1, 12'h200, 8'h66);
        opb(1, 0, 12'h208, 8'h00);
        cyc();
        settle();
        chk("t4 row coll", bus.coll, 1'b0);
        chk("t4 row rd_datab", bus.rd_datab, 8'h99);
        chk("t4 row coll_cnt", bus.coll_cnt, 8'd2);

        opb(1, 1, 12'h050, 8'h44);
        opa(1, 0, 12'h050, 8'h00);
        cyc();
        settle();
        chk("bw fwd rd_dataa", bus.rd_dataa, 8'h44);
        chk("bw rd_valida", bus.rd_valida, 1'b1);
        chk("bw coll", bus.coll, 1'b1);
        chk("bw coll_cnt", bus.coll_cnt, 8'd3);

        opa(1, 0, 12'h040, 8'h00);
        opb(1, 0, 12'h040, 8'h00);
        cyc();
        settle();
        chk("rr coll", bus.coll, 1'b0);
        chk("rr rd_dataa", bus.rd_dataa, 8'h11);
        chk("rr rd_datab", bus.rd_datab, 8'h11);
        chk("rr coll_cnt", bus.coll_cnt, 8'd3);

        for (int k = 0; k < 5; k++) begin
            ww2(8'(k), 1'b0);
            cyc();
            if (k == 1) chk("t5 cnt2", bus2.coll_cnt, 2'd2);
        end
        idle();
        chk("t5 saturate", bus2.coll_cnt, 2'd3);
        ww2(8'h5, 1'b1);
        cyc();
        idle();
        chk("t5 clr+coll", bus2.coll_cnt, 2'd0);
        ww2(8'h6, 1'b0);
        cyc();
        idle();
        chk("t5 recount", bus2.coll_cnt, 2'd1);

        opa(1, 0, 12'h123, 8'h00);
        cyc();
        #2 rst_n = 1'b0;
        #1;
        chk("t6 async rd_dataa", bus.rd_dataa, 8'h00);
        chk("t6 async rd_valida", bus.rd_valida, 1'b0);
        chk("t6 async coll_cnt", bus.coll_cnt, 8'd0);
        chk("t6 async cnt2", bus2.coll_cnt, 2'd0);
        #2;
        rst_n = 1'b1;
        idle();
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t6 no valid", bus.rd_valida, 1'b0);
            chk("t6 data zero", bus.rd_dataa, 8'h00);
        end

        opa(1, 0, 12'h123, 8'h00);
        cyc();
        settle();
        chk("t6 mem kept", bus.rd_dataa, 8'h5A);

        opa(1, 1, 12'h060, 8'h01);
        opb(1, 1, 12'h060, 8'h02);
        cyc();
        idle();
        chk("clr pre", bus.coll_cnt, 8'd1);
        opa(1, 1, 12'h060, 8'h03);
        opb(1, 1, 12'h060, 8'h04);
        bus.coll_clr = 1'b1;
        cyc();
        idle();
        chk("clr prio", bus.coll_cnt, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
